// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side initiator for one port of a dual-port block RAM.
// Accepts (addr, length) commands, issues credit-limited back-to-back reads,
// tracks the fixed RAM read latency with a tag pipeline and buffers returned
// words in a 4-entry FIFO presented as a valid/ready stream.
// Optional feature macro: RAM_READER_REG2_EN selects read latency 2 (RAM with
// extra output register); undefined selects read latency 1.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_length,
    output logic                  ram_enable,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_odata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

`ifdef RAM_READER_REG2_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;

    // Tag pipeline: bit 0 is the cycle after issue, bit LAT-1 lines up with ram_odata.
    logic [LAT-1:0]          tag_vld_q;
    logic [LAT-1:0]          tag_last_q;

    logic [DATA_WIDTH-1:0]   fifo_data_q [DEPTH];
    logic [DEPTH-1:0]        fifo_last_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    issue_c;
    logic                    last_issue_c;
    logic                    push_c;
    logic                    pop_c;
    logic                    credit_c;
    logic [CNT_W-1:0]        inflight_c;
    logic [OCC_W-1:0]        occ_c;

    // Stream side: head of the FIFO is presented directly.
    assign out_valid  = (count_q != '0);
    assign out_data   = fifo_data_q[rd_ptr_q];
    assign out_last   = out_valid & fifo_last_q[rd_ptr_q];
    assign pop_c      = out_valid & out_ready;
    assign push_c     = tag_vld_q[LAT-1];

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ram_enable = issue_c;
    assign ram_write  = 1'b0;
    assign ram_addr   = addr_q;

    // Credit: buffered words plus reads in flight, less a word leaving now, must stay below depth.
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight_c = inflight_c + CNT_W'(tag_vld_q[i]);
        end
        occ_c    = OCC_W'(count_q) + OCC_W'(inflight_c);
        credit_c = occ_c < (pop_c ? OCC_W'(DEPTH + 1) : OCC_W'(DEPTH));
    end

    // Next-state and issue decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        issue_c      = 1'b0;
        last_issue_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && (cmd_length != '0)) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_length;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credit_c) begin
                    issue_c = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        last_issue_c = 1'b1;
                        state_d      = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last word carries the end of the command; nothing else can be in flight.
                if (pop_c && out_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, tag pipeline and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tag_vld_q  <= LAT'({tag_vld_q, issue_c});
            tag_last_q <= LAT'({tag_last_q, last_issue_c});
            wr_ptr_q   <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(pop_c);
            count_q    <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // FIFO storage: capture RAM data when a tagged read matures.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
        end else if (push_c) begin
            fifo_data_q[wr_ptr_q] <= ram_odata;
            fifo_last_q[wr_ptr_q] <= tag_last_q[LAT-1];
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: behavioural RAM, command table,
// scoreboard queue of expected {last, data}, plus stall and reset sequences.
module tb_ram_stream_reader;

`ifdef RAM_READER_REG2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_length = '0;
    logic        ram_enable;
    logic        ram_write;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_odata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_length(cmd_length),
        .ram_enable(ram_enable), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_odata(ram_odata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural RAM with fixed read latency
    logic [7:0] mem [1024];
    logic [7:0] rd1 = 8'h00;
    logic [7:0] rd2 = 8'h00;
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    always @(posedge clock) begin
        if (ram_enable) rd1 <= mem[ram_addr];
        rd2 <= rd1;
    end
    assign ram_odata = (LAT == 2) ? rd2 : rd1;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // out_ready policy: 0 = always 1, 1 = random 50%, 2 = held 0
    int rmode = 0;
    always @(posedge clock) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor state
    logic [8:0] exp_q [$];
    logic [9:0] exp_addr = '0;
    int         en_cnt = 0;
    int         acc_cyc = 0;
    int         first_cyc = 0;
    int         last_pop_cyc = 0;
    bit         seen_first = 1'b1;
    bit         stall_prev = 1'b0;
    bit         last_pop_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clock) begin
        logic [8:0] e;
        if (reset) begin
            stall_prev    = 1'b0;
            last_pop_prev = 1'b0;
        end else begin
            if (last_pop_prev) begin
                check("busy_fall", busy, 0);
                check("cmd_ready_rise", cmd_ready, 1);
            end
            if (stall_prev)
                check("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (ram_enable) begin
                check("ram_addr", ram_addr, exp_addr);
                exp_addr = exp_addr + 10'd1;
                en_cnt++;
            end
            if (out_valid && !seen_first) begin
                first_cyc  = cyc;
                seen_first = 1'b1;
            end
            last_pop_prev = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL extra_word: got 0x%0h last=%0d expected none (cycle %0d)",
                             out_data, out_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {out_last, out_data}, e);
                    if (out_last) begin
                        last_pop_cyc  = cyc;
                        last_pop_prev = 1'b1;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Offer a command, push its expected words, return during the first cycle after accept
    task automatic send_cmd(input logic [9:0] a, input int n);
        int guard;
        logic [9:0] ad;
        @(posedge clock); #1;
        cmd_addr   = a;
        cmd_length = 11'(n);
        cmd_valid  = 1'b1;
        guard      = 0;
        @(negedge clock);
        while (!cmd_ready && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        if (!cmd_ready) begin
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1");
            $fatal(1);
        end
        ad = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), mem[ad]});
            ad = ad + 10'd1;
        end
        exp_addr   = a;
        seen_first = 1'b0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        @(negedge clock);
        if (n > 0) begin
            check("busy_at_c1", busy, 1);
            check("enable_at_c1", ram_enable, 1);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        check("drain_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    typedef struct {
        logic [9:0] addr;
        int         len;
        int         rmode;
    } vec_t;

    vec_t tbl [7];
    int   en0;
    int   quiet_bad;

    initial begin
        tbl[0] = '{addr: 10'h010, len: 4,    rmode: 0};
        tbl[1] = '{addr: 10'h3FE, len: 4,    rmode: 0};
        tbl[2] = '{addr: 10'h000, len: 0,    rmode: 0};
        tbl[3] = '{addr: 10'h123, len: 7,    rmode: 1};
        tbl[4] = '{addr: 10'h000, len: 1024, rmode: 1};
        tbl[5] = '{addr: 10'h3FF, len: 1,    rmode: 0};
        tbl[6] = '{addr: 10'h200, len: 32,   rmode: 1};

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_enable", ram_enable, 0);
        check("rst_ram_write", ram_write, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Table-driven commands
        for (int v = 0; v < 7; v++) begin
            rmode = tbl[v].rmode;
            en0   = en_cnt;
            send_cmd(tbl[v].addr, tbl[v].len);
            if (tbl[v].len == 0) begin
                quiet_bad = 0;
                if (busy || ram_enable || out_valid || !cmd_ready) quiet_bad++;
                repeat (5) begin
                    @(negedge clock);
                    if (busy || ram_enable || out_valid || !cmd_ready) quiet_bad++;
                end
                check("len0_quiet", quiet_bad, 0);
            end else begin
                wait_idle();
            end
            check("enable_count", en_cnt - en0, tbl[v].len);
            if (v == 0) check("first_valid_latency", first_cyc - acc_cyc, 1 + LAT);
            if (tbl[v].rmode == 0 && tbl[v].len > 0)
                check("last_pop_cycle", last_pop_cyc - acc_cyc, LAT + tbl[v].len);
        end

        // Backpressure: 16 words with the consumer stalled for 20 cycles
        rmode = 2;
        repeat (2) @(negedge clock);
        en0 = en_cnt;
        send_cmd(10'h040, 16);
        repeat (20) @(negedge clock);
        check("stall_enables", en_cnt - en0, 4);
        check("stall_valid", out_valid, 1);
        check("stall_head", out_data, 8'h40);
        rmode = 0;
        wait_idle();
        check("stall_total_enables", en_cnt - en0, 16);

        // Reset in the middle of a command, then a fresh single-word read
        rmode = 0;
        send_cmd(10'h080, 8);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", cmd_ready, 1);
        repeat (3) @(negedge clock);
        en0 = en_cnt;
        send_cmd(10'h005, 1);
        wait_idle();
        check("post_rst_enables", en_cnt - en0, 1);
        repeat (4) @(negedge clock);
        check("post_rst_no_stale", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side initiator for one port of the team's true dual-port block RAMs. It accepts a (start address, length) command, issues back-to-back read enables to the RAM port and tracks the RAM's fixed read latency. Returned words are buffered so they can be presented as a valid/ready stream with full backpressure. It sits between a RAM port and any streaming consumer (UART TX, DMA out, checksum engine) and never writes the RAM.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 10, RAM address width; the memory holds 2^ADDR_WIDTH words

Ports:
- clock  in  1  sole clock; RAM port clock must be the same net
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high at the rising edge
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_length  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
- ram_enable  out  1  read enable to RAM port
- ram_write  out  1  tied 0
- ram_addr  out  ADDR_WIDTH  read address to RAM port
- ram_odata  in  DATA_WIDTH  RAM read data
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts
- out_data  out  DATA_WIDTH  word read
- out_last  out  1  high on the final word of a command
- busy  out  1  high from command accept until the last word is popped

## Operation
- Read latency L is fixed: L=1 by default, L=2 under the macro (see Configuration). Data for an enable in cycle N is sampled from ram_odata at the end of cycle N+L.
- The output FIFO is registered, 4 entries deep, and carries {last, data}. A valid-tag shift register of length L carries the enable and last flag alongside the RAM pipeline.
- Credit rule: a read is issued only if fifo_count + inflight − pop_this_cycle < 4. The FIFO never overflows.
- FSM, states IDLE, ISSUE, DRAIN.
  - IDLE: cmd_ready=1 and busy=0. On accept with cmd_length=0, stay in IDLE; no reads and no words are produced. On accept with length>0, load addr and remaining=cmd_length, then go to ISSUE.
  - ISSUE: in every cycle with credit, set ram_enable=1 and ram_addr=addr, then addr++ and remaining--. The read with remaining==1 is tagged last, and the FSM goes to DRAIN.
  - DRAIN: stay until inflight==0 and the FIFO is empty (the last word has been popped), then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top address goes to 0. A length of 2^ADDR_WIDTH reads every word exactly once.
- The next command is accepted no earlier than the cycle after the last word is popped. Commands never overlap.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Reset in any state returns to IDLE and clears the FIFO, the tag pipeline and the counters. RAM data returning after reset is discarded.

## Timing
- Reset values: cmd_ready=1, ram_enable=0, ram_write=0, ram_addr=0, out_valid=0, out_last=0, busy=0, out_data=0.
- Command accepted at the end of cycle C0: ram_enable=1 in C1 and busy=1 from C1. The first out_valid is in C(2+L), i.e. C3 for L=1 and C4 for L=2.
- With out_ready held at 1, one word per clock is sustained for both L values. A command of n words completes with its last pop in cycle C(1+L+n).
- Backpressure: with out_ready=0, at most 4 words are outstanding and ram_enable drops within one cycle once credit is exhausted. Issue resumes in the cycle out_ready pops a word.
- busy falls in the cycle after the out_last pop; cmd_ready rises in that same cycle.

## Configuration
- RAM_READER_REG2_EN defined: L=2, matching RAMs built with the extra output register. The tag pipeline has 2 stages.
- Not defined: L=1, matching RAMs with an unregistered output. The tag pipeline has 1 stage.
- All other behaviour, including the FIFO depth, is identical.

## Test plan
- RAM preloaded mem[i]=i&0xFF; cmd addr=0x010, len=4, out_ready=1 → 0x10,0x11,0x12,0x13 on consecutive cycles, out_last only on 0x13, first out_valid at C3 (L=1) or C4 (L=2).
- cmd addr=0x3FE, len=4 → ram_addr sequence 0x3FE,0x3FF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
- len=0 → cmd_ready stays 1, busy stays 0, no ram_enable, no out_valid.
- len=16 with out_ready=0 for 20 cycles → exactly 4 ram_enable pulses, out_data=first word held stable. Then out_ready=1 → all 16 words delivered in order with none lost or duplicated.
- len=1024 from addr 0 with out_ready random 50% → 1024 words matching mem, out_last once, ram_enable count=1024.
- reset asserted 2 cycles after the first ram_enable of a len=8 command → next cycle out_valid=0, busy=0, cmd_ready=1. No stale word appears after a new len=1 command at addr 5, which returns only 0x05.
